// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response handshake of the load/store unit.
interface load_store_unit_if;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        RespValid;
  logic [31:0] RespRData;
  logic        Fault;

  modport master (
    output ReqValid, ReqWrite, ReqSize,
    output ReqSigned, ReqAddr, ReqWData,
    input  ReqReady, RespValid, RespRData, Fault
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqSize,
    input  ReqSigned, ReqAddr, ReqWData,
    output ReqReady, RespValid, RespRData, Fault
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit driving a 1-cycle registered-read word memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module load_store_unit #(
  parameter int MEM_WORDS = 1024
) (
  input  logic               Clk,
  input  logic               Rst,
  load_store_unit_if.slave   Lsu,
  output logic [31:0]        MemAddress,
  output logic [31:0]        MemWriteData,
  output logic               MemWrite,
  output logic               MemRead,
  input  logic [31:0]        MemReadData
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  localparam int          AW      = $clog2(MEM_WORDS);
  localparam logic [31:0] IdxMask = (32'd1 << AW) - 32'd1;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    RD_WAIT,
    WR
  } state_t;

  state_t      state;
  logic        wrL;
  logic        sgnL;
  logic [1:0]  sizeL;
  logic [1:0]  laneL;
  logic [31:0] wdL;
  logic        misal;

  assign misal =
    (Lsu.ReqSize == 2'b01 && Lsu.ReqAddr[0]) ||
    (Lsu.ReqSize[1] && Lsu.ReqAddr[1:0] != 2'b00);

  function automatic logic [31:0] extractLoad(
    input logic [31:0] w,
    input logic [1:0]  size,
    input logic [1:0]  lane,
    input logic        sgn
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    unique case (1'b1)
      size == 2'b00: r = {{24{sgn & b[7]}}, b};
      size == 2'b01: r = {{16{sgn & h[15]}}, h};
      default:       r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] mergeStore(
    input logic [31:0] w,
    input logic [31:0] wd,
    input logic [1:0]  size,
    input logic [1:0]  lane
  );
    logic [31:0] r;
    r = w;
    unique case (1'b1)
      size == 2'b00: r[{lane, 3'b000} +: 8]    = wd[7:0];
      size == 2'b01: r[{lane[1], 4'b0000} +: 16] = wd[15:0];
      default:       r = wd;
    endcase
    return r;
  endfunction

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state         <= IDLE;
      Lsu.ReqReady  <= 1'b1;
      Lsu.RespValid <= 1'b0;
      Lsu.Fault     <= 1'b0;
      Lsu.RespRData <= '0;
      MemWrite      <= 1'b0;
      MemRead       <= 1'b0;
      MemAddress    <= '0;
      MemWriteData  <= '0;
      wrL           <= 1'b0;
      sgnL          <= 1'b0;
      sizeL         <= '0;
      laneL         <= '0;
      wdL           <= '0;
    end else begin
      Lsu.RespValid <= 1'b0;
      Lsu.Fault     <= 1'b0;
      MemRead       <= 1'b0;
      MemWrite      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Lsu.ReqValid) begin
            wrL   <= Lsu.ReqWrite;
            sgnL  <= Lsu.ReqSigned;
            sizeL <= Lsu.ReqSize;
            laneL <= Lsu.ReqAddr[1:0];
            wdL   <= Lsu.ReqWData;
            if (TrapEn && misal) begin
              // Trap answers immediately without touching memory.
              Lsu.RespValid <= 1'b1;
              Lsu.Fault     <= 1'b1;
              Lsu.RespRData <= '0;
            end else begin
              Lsu.ReqReady <= 1'b0;
              MemAddress   <= {2'b00, Lsu.ReqAddr[31:2]} & IdxMask;
              if (Lsu.ReqWrite && Lsu.ReqSize[1]) begin
                state        <= WR;
                MemWrite     <= 1'b1;
                MemWriteData <= Lsu.ReqWData;
              end else begin
                state   <= RD;
                MemRead <= 1'b1;
              end
            end
          end
        end
        RD: state <= RD_WAIT;
        RD_WAIT: begin
          if (wrL) begin
            state        <= WR;
            MemWrite     <= 1'b1;
            MemWriteData <= mergeStore(MemReadData, wdL, sizeL, laneL);
          end else begin
            state         <= IDLE;
            Lsu.ReqReady  <= 1'b1;
            Lsu.RespValid <= 1'b1;
            Lsu.RespRData <= extractLoad(MemReadData, sizeL, laneL, sgnL);
          end
        end
        WR: begin
          state         <= IDLE;
          Lsu.ReqReady  <= 1'b1;
          Lsu.RespValid <= 1'b1;
          Lsu.RespRData <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural memory model.
module tb_load_store_unit;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic [31:0] MemReadData;
  logic        MemWrite;
  logic        MemRead;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Lsu          (bus.slave),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .MemReadData  (MemReadData)
  );

  always #5 Clk = ~Clk;

  logic [31:0] mem    [1024];
  logic [31:0] refMem [1024];

  always @(posedge Clk) begin
    if (MemWrite) mem[MemAddress[9:0]] <= MemWriteData;
    MemReadData <= mem[MemAddress[9:0]];
  end

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          wrCycles = 0;
  int          rdCycles = 0;
  logic [31:0] lastWData = '0;
  logic [31:0] lastRData = '0;
  logic        lastFault = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference: lanes by part-select on a word array, no FSM notion.
  function automatic void predict(
    input bit wr, input logic [1:0] size, input bit sgn,
    input logic [31:0] addr, input logic [31:0] wd,
    output exp_t e, output int lat
  );
    int          idx;
    int          sz;
    int          k;
    int          h;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] hw;
    bit          mis;
    idx = int'(addr[11:2]);
    sz  = (size == 2'd3) ? 2 : int'(size);
    k   = int'(addr[1:0]);
    h   = int'(addr[1]);
    w   = refMem[idx];
    mis = (sz == 1 && addr[0]) || (sz == 2 && addr[1:0] != 2'b00);
    e.rdata = '0;
    e.fault = 1'b0;
    e.due   = 0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) begin
      e.fault = 1'b1;
      lat = 1;
      return;
    end
`else
    if (mis) lat = 0;
`endif
    if (!wr) begin
      lat = 3;
      b  = w[8*k +: 8];
      hw = w[16*h +: 16];
      if (sz == 0) e.rdata = {{24{sgn & b[7]}}, b};
      else if (sz == 1) e.rdata = {{16{sgn & hw[15]}}, hw};
      else e.rdata = w;
    end else if (sz == 2) begin
      lat = 2;
      refMem[idx] = wd;
    end else begin
      lat = 4;
      if (sz == 0) w[8*k +: 8] = wd[7:0];
      else w[16*h +: 16] = wd[15:0];
      refMem[idx] = w;
    end
  endfunction

  always @(negedge Clk) begin
    if (!Rst) begin
      check("mem_rw_excl", {31'b0, MemRead & MemWrite}, 32'd0);
      if (MemWrite) begin
        wrCycles++;
        lastWData = MemWriteData;
      end
      if (MemRead) rdCycles++;
      if (bus.RespValid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: RespValid=1, required 0");
        end else begin
          exp_t e;
          e = sb.pop_front();
          lastRData = bus.RespRData;
          lastFault = bus.Fault;
          check("resp_rdata", bus.RespRData, e.rdata);
          check("resp_fault", {31'b0, bus.Fault}, {31'b0, e.fault});
          check("resp_latency", cyc, e.due);
          check("ready_in_resp", {31'b0, bus.ReqReady}, 32'd1);
        end
      end else begin
        check("fault_idle", {31'b0, bus.Fault}, 32'd0);
      end
    end
  end

  task automatic issue(input bit wr, input logic [1:0] size, input bit sgn,
                       input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    int   lat;
    int   n;
    bus.ReqValid  = 1'b1;
    bus.ReqWrite  = wr;
    bus.ReqSize   = size;
    bus.ReqSigned = sgn;
    bus.ReqAddr   = addr;
    bus.ReqWData  = wd;
    n = 0;
    while (!bus.ReqReady && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (!bus.ReqReady) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: ReqReady=0, required 1");
      bus.ReqValid = 1'b0;
      return;
    end
    @(posedge Clk);
    #1;
    predict(wr, size, sgn, addr, wd, e, lat);
    e.due = cyc + lat - 1;
    sb.push_back(e);
    @(negedge Clk);
    bus.ReqValid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d responses pending, required 0",
               sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          wrB;
    int          rdB;
    int          nmis;
    logic [31:0] w4;
    logic [31:0] w8;
    for (int i = 0; i < 1024; i++) begin
      mem[i]    = $urandom();
      refMem[i] = mem[i];
    end
    mem[5]    = 32'h8899AABB;
    refMem[5] = 32'h8899AABB;
    bus.ReqValid  = 1'b0;
    bus.ReqWrite  = 1'b0;
    bus.ReqSize   = 2'b00;
    bus.ReqSigned = 1'b0;
    bus.ReqAddr   = '0;
    bus.ReqWData  = '0;
    repeat (3) @(negedge Clk);
    check("rst_ready", {31'b0, bus.ReqReady}, 32'd1);
    check("rst_respvalid", {31'b0, bus.RespValid}, 32'd0);
    check("rst_fault", {31'b0, bus.Fault}, 32'd0);
    check("rst_memwrite", {31'b0, MemWrite}, 32'd0);
    check("rst_memread", {31'b0, MemRead}, 32'd0);
    check("rst_rdata", bus.RespRData, 32'd0);
    check("rst_memaddr", MemAddress, 32'd0);
    check("rst_memwdata", MemWriteData, 32'd0);
    Rst = 1'b0;
    @(negedge Clk);

    wrB = wrCycles;
    issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    drain();
    check("ldw_data", lastRData, 32'h8899AABB);
    check("ldw_nowrite", wrCycles, wrB);

    issue(1'b0, 2'b00, 1'b1, 32'h16, 32'h0);
    drain();
    check("ldb_signed", lastRData, 32'hFFFFFF99);
    issue(1'b0, 2'b01, 1'b0, 32'h16, 32'h0);
    drain();
    check("ldh_unsigned", lastRData, 32'h00008899);

    wrB = wrCycles;
    issue(1'b1, 2'b00, 1'b0, 32'h15, 32'h5A);
    drain();
    check("stb_wrcycles", wrCycles, wrB + 1);
    check("stb_wdata", lastWData, 32'h88995ABB);
    check("stb_mem5", mem[5], 32'h88995ABB);

    issue(1'b1, 2'b10, 1'b0, 32'hFFC, 32'hFFFFFFEC);
    issue(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0);
    drain();
    check("stw_mem1023", mem[1023], 32'hFFFFFFEC);
    check("b2b_load", lastRData, 32'hFFFFFFEC);

    wrB = wrCycles;
    w8  = mem[8];
    bus.ReqValid  = 1'b1;
    bus.ReqWrite  = 1'b1;
    bus.ReqSize   = 2'b01;
    bus.ReqSigned = 1'b0;
    bus.ReqAddr   = 32'h22;
    bus.ReqWData  = 32'h0000BEEF;
    @(posedge Clk);
    @(negedge Clk);
    bus.ReqValid = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    bus.ReqValid = 1'b1;
    bus.ReqSize  = 2'b10;
    bus.ReqAddr  = 32'h20;
    @(negedge Clk);
    Rst = 1'b0;
    bus.ReqValid = 1'b0;
    check("midrst_ready", {31'b0, bus.ReqReady}, 32'd1);
    check("midrst_memwrite", {31'b0, MemWrite}, 32'd0);
    repeat (6) @(negedge Clk);
    check("midrst_nowrite", wrCycles, wrB);
    check("midrst_mem8", mem[8], w8);
    check("midrst_ref8", refMem[8], w8);

    rdB = rdCycles;
    w4  = refMem[4];
    issue(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
    drain();
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_fault", {31'b0, lastFault}, 32'd1);
    check("mis_rdata", lastRData, 32'd0);
    check("mis_noread", rdCycles, rdB);
`else
    check("mis_fault", {31'b0, lastFault}, 32'd0);
    check("mis_rdata", lastRData, w4);
    check("mis_read", rdCycles, rdB + 1);
`endif

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 1) == 1) ? $urandom() :
          32'($urandom_range(0, 63));
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), a, $urandom());
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end
    drain();
    repeat (4) @(negedge Clk);

    nmis = 0;
    for (int i = 0; i < 1024; i++)
      if (mem[i] !== refMem[i]) nmis++;
    check("mem_final_mismatches", nmis, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage initiator that drives the word-addressed, 1-cycle registered-read data memory (1024 x 32).
- Accepts byte, half and word loads and stores on byte addresses from the pipeline.
- Converts each request into memory cycles:
  - sub-word stores use read-modify-write, because the memory has no byte enables;
  - loads are extracted and then sign- or zero-extended.
- Returns one response per request over a valid/ready handshake.

Parameters:
- MEM_WORDS, 1024, memory depth in words; only the low clog2(MEM_WORDS) bits of the word index are significant.

Ports:
- Clk  in  1  rising-edge clock, shared with data memory
- Rst  in  1  synchronous, active-high reset
- ReqValid  in  1  request present
- ReqReady  out  1  unit can accept; request taken when ReqValid & ReqReady at a rising edge
- ReqWrite  in  1  1 = store, 0 = load
- ReqSize  in  2  00 byte, 01 half, 10 word, 11 treated as word
- ReqSigned  in  1  load sign-extend (1) / zero-extend (0)
- ReqAddr  in  32  byte address
- ReqWData  in  32  store data, right-justified
- RespValid  out  1  one-cycle pulse: load data valid or store committed
- RespRData  out  32  extended load data; 0 for stores
- Fault  out  1  misaligned request, pulses with RespValid
- MemAddress  out  32  word index = {2'b00, ReqAddr[31:2]}
- MemWriteData  out  32  write word to memory
- MemWrite  out  1  memory write enable
- MemRead  out  1  memory read strobe
- MemReadData  in  32  memory ReadData; valid the cycle after MemAddress is sampled

Behaviour:
- All outputs are registered.
- Reset values:
  - ReqReady = 1.
  - RespValid, Fault, MemWrite, MemRead = 0.
  - RespRData, MemAddress, MemWriteData = 0.
  - State = IDLE.
- FSM states: IDLE, RD, RD_WAIT, WR.
- ReqReady is 1 only in IDLE. Requests are latched on acceptance.
- Load path: IDLE -> RD (MemRead = 1) -> RD_WAIT (MemReadData valid) -> IDLE.
  - RespValid is visible 3 cycles after the acceptance edge.
- Word store path: IDLE -> WR (MemWrite = 1, MemWriteData = ReqWData) -> IDLE.
  - RespValid is visible 2 cycles after the acceptance edge.
- Byte/half store path: IDLE -> RD -> RD_WAIT -> WR -> IDLE.
  - The merged word is formed from MemReadData in RD_WAIT.
  - RespValid is visible 4 cycles after the acceptance edge.
- The unit returns to IDLE on the same edge that raises RespValid.
  - ReqReady = 1 in the response cycle, so back-to-back requests are legal.
- MemRead and MemWrite are never both 1. Both are 0 outside RD and WR.
- MemAddress holds its last value when the unit is idle.
- Lanes are little-endian:
  - byte k = bits [8k+7:8k], with k = ReqAddr[1:0];
  - half h = bits [16h+15:16h], with h = ReqAddr[1].
- Load extract:
  - byte/half are extended by ReqSigned;
  - word passes through unchanged.
- Store merge:
  - only the addressed lane is replaced by the low 8 or 16 bits of ReqWData;
  - all other lanes keep the MemReadData values.
- Word index wraps modulo MEM_WORDS. There is no range error.
- Reset mid-operation:
  - the FSM goes to IDLE and all strobes clear at the next edge;
  - no RespValid is issued for the aborted request;
  - a MemWrite already high in the Rst cycle is still committed by the memory;
  - a request presented during Rst is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - a half with ReqAddr[0] = 1, or a word with ReqAddr[1:0] != 0, is accepted but performs no memory access;
  - IDLE -> IDLE, with RespValid = 1 and Fault = 1 on the next cycle;
  - RespRData = 0 and memory contents are unchanged.
- Undefined:
  - the offending low address bits are ignored, so the access is forced aligned;
  - Fault is tied 0.

Test Plan:
- Preload mem[5] = 32'h8899AABB; load word at addr 0x14 -> RespValid 3 cycles after acceptance, RespRData = 32'h8899AABB, MemWrite never 1.
- Same word; signed byte load at 0x16 -> 32'hFFFFFF99; unsigned half load at 0x16 -> 32'h00008899.
- Store byte 8'h5A to 0x15 -> MemWrite for exactly 1 cycle, MemWriteData = 32'h88995ABB, mem[5] updated, RespValid 4 cycles after acceptance.
- Store word 32'hFFFFFFEC at 0xFFC, then load it back-to-back:
  - second request accepted in the store's response cycle;
  - mem[1023] = -20;
  - load returns 32'hFFFFFFEC.
- Assert Rst in the RD_WAIT cycle of a half store -> no MemWrite, no RespValid, ReqReady = 1 after reset, memory unchanged.
- With LSU_MISALIGN_TRAP_EN, load word at 0x13 -> RespValid = 1 and Fault = 1 one cycle after acceptance, MemRead stays 0. Without the macro -> mem[4] returned, Fault = 0.
